disp_scan_4dig: RTL

DISP_SCAN_4DIG -- requirements
Module: disp_scan_4dig

---
 rtl/disp_scan_4dig_pkg.sv | 35 +++
 rtl/disp_scan_4dig_prescaler.sv | 32 +++
 rtl/disp_scan_4dig.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/disp_scan_4dig_pkg.sv
// ---------------------------------------------------------------------------
// disp_scan_4dig_pkg
// Shared constants, types and small helpers for the 4-digit display scanner.
//   NDIG        : number of multiplexed digits
//   AN_OFF      : anode pattern with every digit switched off (active-low)
//   nibble_t    : one hex digit value
//   idx_t       : digit index type
//   disp_set_t  : one complete register set (value, points, blanks)
//   SET_RESET   : register-set contents after reset (all digits blanked)
// ---------------------------------------------------------------------------
package disp_scan_4dig_pkg;

  localparam int         NDIG   = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [3:0] nibble_t;
  typedef logic [1:0] idx_t;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  points;
    logic [3:0]  blanks;
  } disp_set_t;

  localparam disp_set_t SET_RESET = '{value: 16'h0000, points: 4'h0, blanks: 4'hF};

  // Active-low one-cold anode pattern for the given digit.
  function automatic logic [3:0] an_for_idx(input idx_t idx);
    logic [3:0] pattern;
    pattern      = AN_OFF;
    pattern[idx] = 1'b0;
    return pattern;
  endfunction

endpackage

// File: rtl/disp_scan_4dig_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
// Free-running DIV_W-bit counter that sets the digit hold time. The tick
// output is high for the single cycle in which the counter sits at all-ones,
// i.e. once every 2^DIV_W cycles.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (counter cleared to 0)
//   tick : one-cycle strobe, counter == 2^DIV_W-1
// ---------------------------------------------------------------------------
module scan_prescaler #(
  parameter int DIV_W = 17
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      // Natural wrap from all-ones back to zero.
      r_count <= r_count + DIV_W'(1);
    end
  end

  assign tick = &r_count;

endmodule

// File: rtl/disp_scan_4dig.sv
// ---------------------------------------------------------------------------
// disp_scan_4dig
// Time-multiplexed scanner for a 4-digit 7-segment display driven through an
// external hex decoder. New display contents are written into a shadow set
// and only promoted to the active set at the frame boundary (digit 3 -> 0),
// so a single frame never mixes old and new data.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   load       : one-cycle request to capture hexs/points/blanks
//   hexs       : nibble i drives digit i (digit 0 rightmost)
//   points     : decimal point per digit, active-high
//   blanks     : blank per digit, active-high
//   an         : anode enables, active-low, at most one low
//   hex        : nibble for the decoder D3..D0
//   point      : decimal point for the decoder
//   le         : blank for the decoder LE input
//   digit_idx  : digit currently being scanned (undelayed index register)
//   frame_done : one-cycle pulse following each 3 -> 0 wrap
// ---------------------------------------------------------------------------
module disp_scan_4dig
  import disp_scan_4dig_pkg::*;
#(
  parameter int DIV_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] hexs,
  input  logic [3:0]  points,
  input  logic [3:0]  blanks,
  output logic [3:0]  an,
  output logic [3:0]  hex,
  output logic        point,
  output logic        le,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  // -------------------------------------------------------------------------
  // Digit hold-time prescaler
  // -------------------------------------------------------------------------
  logic w_tick;

  scan_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  idx_t      r_idx;
  disp_set_t r_shadow;
  disp_set_t r_active;
  logic      r_pending;
  logic      r_frame_done;
  logic [3:0] r_an;
  nibble_t   r_hex;
  logic      r_point;
  logic      r_le;

  disp_set_t w_load_set;
  disp_set_t w_shadow_next;
  disp_set_t w_active_next;
  logic      w_pending_next;
  logic      w_wrap;

  assign w_load_set = '{value: hexs, points: points, blanks: blanks};

  // Frame boundary: the tick that moves the index from the last digit to 0.
  assign w_wrap = w_tick && (r_idx == idx_t'(NDIG - 1));

  // -------------------------------------------------------------------------
  // Active set split into per-digit nibbles for the output mux
  // -------------------------------------------------------------------------
  nibble_t w_act_nib [NDIG];

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_nib
      assign w_act_nib[gi] = r_active.value[4*gi +: 4];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Shadow / active update
  // A load that lands on the wrap tick bypasses the shadow stage and goes
  // straight to active; otherwise the shadow (last load wins) is promoted at
  // the next wrap.
  // -------------------------------------------------------------------------
  always_comb begin
    w_shadow_next  = r_shadow;
    w_active_next  = r_active;
    w_pending_next = r_pending;

    if (load) begin
      w_shadow_next = w_load_set;
    end

    if (load && w_wrap) begin
      w_active_next  = w_load_set;
      w_pending_next = 1'b0;
    end else if (load) begin
      w_pending_next = 1'b1;
    end else if (w_wrap && r_pending) begin
      w_active_next  = r_shadow;
      w_pending_next = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Sequential state and registered outputs
  // Outputs are registered from the pre-edge index and active set, so the
  // displayed digit trails digit_idx by one cycle but always pairs an index
  // with data from the same frame.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_shadow     <= SET_RESET;
      r_active     <= SET_RESET;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_an         <= AN_OFF;
      r_hex        <= '0;
      r_point      <= 1'b0;
      r_le         <= 1'b1;
    end else begin
      if (w_tick) begin
        r_idx <= r_idx + idx_t'(1);
      end
      r_shadow     <= w_shadow_next;
      r_active     <= w_active_next;
      r_pending    <= w_pending_next;
      r_frame_done <= w_wrap;
      r_an         <= an_for_idx(r_idx);
      r_hex        <= w_act_nib[r_idx];
      r_point      <= r_active.points[r_idx];
      r_le         <= r_active.blanks[r_idx];
    end
  end

  assign an         = r_an;
  assign hex        = r_hex;
  assign point      = r_point;
  assign le         = r_le;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;

endmodule
